pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage WISC pipeline (IF, ID, EX, MEM, WB). It decides, every cycle, which pipeline registers advance, hold, or are bubbled. It covers load-use hazards, branch mispredicts resolved in ID, I-mem and D-mem multi-cycle waits, and HLT drain. Its outputs drive the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB register enables and flushes; its `stall` output feeds the trace monitor.

Parameters:
REG_W, 4, register-id width (16 GPRs)
DRAIN_CYCLES, 3, cycles after HLT leaves ID until it retires (EX, MEM, WB)
CNT_W, 16, perf counter width (only with PERF_CNT_EN)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
id_rs  in  REG_W  ID source reg 1
id_rt  in  REG_W  ID source reg 2
id_rs_used  in  1  id_rs is actually read
id_rt_used  in  1  id_rt is actually read
ex_rd  in  REG_W  EX destination reg
ex_mem_read  in  1  EX instruction is LW
id_br_mispred  in  1  branch in ID resolved mispredicted (redirect PC)
if_busy  in  1  I-mem has not returned the fetch this cycle
mem_busy  in  1  D-mem access in MEM not complete this cycle
id_halt  in  1  HLT decoded in ID
pc_en  out  1  PC may update
if_id_en  out  1  IF/ID may load
if_id_flush  out  1  IF/ID loads NOP
id_ex_en  out  1  ID/EX may load
id_ex_flush  out  1  ID/EX loads NOP
ex_mem_en  out  1  EX/MEM may load
mem_wb_en  out  1  MEM/WB may load
stall  out  1  any freeze of PC or IF/ID this cycle
halted  out  1  pipeline fully drained after HLT

Behaviour:
- Outputs are combinational from the registered state plus the current inputs. Each decision takes effect at the next rising edge.
- States: RUN, DRAIN, HALTED. Registered drain counter dcnt is sized for 0..DRAIN_CYCLES.
- Reset: state=RUN, dcnt=0, counters=0. During rst, all enables = 1, flushes = 1, stall=0, halted=0.
- Hazard definitions:
  - load_use = ex_mem_read & ex_rd!=0 & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)). Register 0 never creates a hazard.
- Priority in RUN, highest first:
  1. mem_busy: all five enables = 0, no flushes, stall=1. A mem_busy freeze masks every other event that cycle; those events are re-evaluated next cycle.
  2. load_use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1, stall=1. id_br_mispred and id_halt are ignored this cycle because the ID instruction is not valid yet.
  3. id_br_mispred: pc_en=1 (redirect), if_id_flush=1, all other enables = 1, stall=0.
  4. id_halt: transition to DRAIN, dcnt=DRAIN_CYCLES. pc_en=0, if_id_flush=1, ID/EX loads HLT normally.
  5. if_busy: pc_en=0, if_id_flush=1 (bubble into ID), downstream enables = 1, stall=1.
  6. Otherwise all enables = 1, no flushes.
- If id_br_mispred and if_busy are both active, the flush wins. pc_en=1 still loads the redirect target.
- DRAIN:
  - pc_en=0, if_id_flush=1, id_ex_flush=1. EX/MEM and MEM/WB advance unless mem_busy.
  - dcnt decrements only when mem_busy=0.
  - When dcnt==1 and mem_busy=0, go to HALTED.
  - stall=1.
- HALTED: all enables = 0, halted=1, stall=1. The block stays here until rst.
- Reset asserted in any state returns to RUN the next edge, regardless of pending busy signals.

Optional Feature:
- Macro: PIPELINE_HAZARD_CTRL_PERF_CNT_EN.
- When defined, adds outputs:
  - cnt_load_use[CNT_W]
  - cnt_mispred[CNT_W]
  - cnt_mem_wait[CNT_W]
  - cnt_cycles[CNT_W]
- Each counter increments once per cycle in which its condition wins priority. cnt_cycles increments every non-HALTED cycle.
- Counters saturate at all-ones and clear on rst.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - enum ctrl_state_t {RUN, DRAIN, HALTED}
  - struct stage_ctrl_t bundling the en/flush bits
  - localparam REG_ZERO
- One sub-module, hazard_detect: purely combinational load_use compare, reused by the forwarding unit.
- FSM, priority mux and counters stay in the top module.

Test Plan:
- LW r3 in EX, ID reads r3 (rs_used) → exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. The next cycle (ex_mem_read=0) is all enables 1.
- LW r0 in EX, ID reads r0 → no stall; all enables 1.
- mem_busy held 4 cycles while load_use and id_br_mispred are also active → 4 cycles of all enables 0. Cycle 5 then shows the load_use response, and the mispred is not acted on.
- id_br_mispred with if_busy=1 → if_id_flush=1, pc_en=1, stall=0.
- id_halt, then mem_busy for 2 cycles during DRAIN → halted rises exactly DRAIN_CYCLES+2 = 5 cycles after the HLT cycle and stays 1. rst then returns to RUN with halted=0.
- With PERF_CNT_EN and CNT_W=4: 20 load-use cycles → cnt_load_use reads 15 (saturated).

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state, stage-control bundle and constants for WISC pipeline control
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} ctrl_state_t;
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } stage_ctrl_t;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use compare between the ID source registers and a load in EX
module hazard_detect import pipeline_ctrl_pkg::*; #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);
  assign load_use = ex_mem_read && ex_rd != REG_W'(REG_ZERO) &&
                    ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline; PIPELINE_HAZARD_CTRL_PERF_CNT_EN adds perf counters
module pipeline_hazard_ctrl import pipeline_ctrl_pkg::*; #(
  parameter int REG_W = 4,
  parameter int DRAIN_CYCLES = 3
`ifdef PIPELINE_HAZARD_CTRL_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             id_br_mispred,
  input  logic             if_busy,
  input  logic             mem_busy,
  input  logic             id_halt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             stall,
  output logic             halted
`ifdef PIPELINE_HAZARD_CTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0] cnt_load_use
  , output logic [CNT_W-1:0] cnt_mispred
  , output logic [CNT_W-1:0] cnt_mem_wait
  , output logic [CNT_W-1:0] cnt_cycles
`endif
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  ctrl_state_t state;
  logic [DW-1:0] dcnt;
  logic load_use;
  stage_ctrl_t sc;
  hazard_detect #(.REG_W(REG_W)) u_hd (
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .load_use(load_use)
  );
  always_comb begin
    sc = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
           id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1};
    stall = 1'b0;
    halted = 1'b0;
    if (rst) begin
      sc.if_id_flush = 1'b1;
      sc.id_ex_flush = 1'b1;
    end else if (state == HALTED) begin
      sc = '0;
      stall = 1'b1;
      halted = 1'b1;
    end else if (state == DRAIN) begin
      sc.pc_en = 1'b0;
      sc.if_id_flush = 1'b1;
      sc.id_ex_flush = 1'b1;
      sc.ex_mem_en = !mem_busy;
      sc.mem_wb_en = !mem_busy;
      stall = 1'b1;
    end else if (mem_busy) begin
      sc = '0;
      stall = 1'b1;
    end else if (load_use) begin
      sc.pc_en = 1'b0;
      sc.if_id_en = 1'b0;
      sc.id_ex_flush = 1'b1;
      stall = 1'b1;
    end else if (id_br_mispred) begin
      sc.if_id_flush = 1'b1;
    end else if (id_halt || if_busy) begin
      sc.pc_en = 1'b0;
      sc.if_id_flush = 1'b1;
      stall = 1'b1;
    end
  end
  assign {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en} = sc;
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      dcnt <= '0;
    end else if (state == RUN && !mem_busy && !load_use && !id_br_mispred && id_halt) begin
      state <= DRAIN;
      dcnt <= DW'(DRAIN_CYCLES);
    end else if (state == DRAIN && !mem_busy) begin
      dcnt <= dcnt - 1'b1;
      state <= dcnt == DW'(1) ? HALTED : DRAIN;
    end
`ifdef PIPELINE_HAZARD_CTRL_PERF_CNT_EN
  logic win_lu, win_mp, win_mw, live;
  assign live = state != HALTED;
  assign win_lu = state == RUN && !mem_busy && load_use;
  assign win_mp = state == RUN && !mem_busy && !load_use && id_br_mispred;
  assign win_mw = live && mem_busy;
  always_ff @(posedge clk)
    if (rst) begin
      cnt_load_use <= '0;
      cnt_mispred <= '0;
      cnt_mem_wait <= '0;
      cnt_cycles <= '0;
    end else begin
      cnt_load_use <= cnt_load_use + CNT_W'(win_lu && !(&cnt_load_use));
      cnt_mispred <= cnt_mispred + CNT_W'(win_mp && !(&cnt_mispred));
      cnt_mem_wait <= cnt_mem_wait + CNT_W'(win_mw && !(&cnt_mem_wait));
      cnt_cycles <= cnt_cycles + CNT_W'(live && !(&cnt_cycles));
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench; expected control vectors queued at drive, compared at negedge
module tb_pipeline_hazard_ctrl;
  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, stall, halted}
  localparam logic [8:0] E_RST  = 9'b111111100;
  localparam logic [8:0] E_NORM = 9'b110101100;
  localparam logic [8:0] E_MEMW = 9'b000000010;
  localparam logic [8:0] E_LU   = 9'b000111110;
  localparam logic [8:0] E_MISP = 9'b111101100;
  localparam logic [8:0] E_IFB  = 9'b011101110;
  localparam logic [8:0] E_DRN  = 9'b011111110;
  localparam logic [8:0] E_DRNB = 9'b011110010;
  localparam logic [8:0] E_HALT = 9'b000000011;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_rs_used = 1'b0, id_rt_used = 1'b0, ex_mem_read = 1'b0;
  logic id_br_mispred = 1'b0, if_busy = 1'b0, mem_busy = 1'b0, id_halt = 1'b0;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, stall, halted;
`ifdef PIPELINE_HAZARD_CTRL_PERF_CNT_EN
  logic [3:0] cnt_load_use, cnt_mispred, cnt_mem_wait, cnt_cycles;
`endif
  int n_tests = 0;
  int n_fail = 0;
  typedef struct { string tag; logic [8:0] exp; } sb_t;
  sb_t sbq[$];
  sb_t s;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(
    .REG_W(4), .DRAIN_CYCLES(3)
`ifdef PIPELINE_HAZARD_CTRL_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .id_br_mispred(id_br_mispred), .if_busy(if_busy), .mem_busy(mem_busy), .id_halt(id_halt),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .stall(stall), .halted(halted)
`ifdef PIPELINE_HAZARD_CTRL_PERF_CNT_EN
    , .cnt_load_use(cnt_load_use), .cnt_mispred(cnt_mispred)
    , .cnt_mem_wait(cnt_mem_wait), .cnt_cycles(cnt_cycles)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic [3:0] rs, input logic [3:0] rt,
                      input logic rsu, input logic rtu, input logic [3:0] rd, input logic mr,
                      input logic mp, input logic ib, input logic mb, input logic hl,
                      input logic [8:0] e);
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu; ex_rd = rd;
    ex_mem_read = mr; id_br_mispred = mp; if_busy = ib; mem_busy = mb; id_halt = hl;
    sbq.push_back('{tag, e});
  endtask
  always @(negedge clk)
    if (sbq.size() != 0) begin
      s = sbq.pop_front();
      chk(s.tag, 32'({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
                      mem_wb_en, stall, halted}), 32'(s.exp));
    end
  initial begin
    step("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST);
    step("reset1", 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, E_RST);
    step("idle", 0, 1, 2, 1, 1, 5, 0, 0, 0, 0, 0, E_NORM);
    step("lu_rs", 0, 3, 7, 1, 0, 3, 1, 0, 0, 0, 0, E_LU);
    step("lu_after", 0, 3, 7, 1, 0, 3, 0, 0, 0, 0, 0, E_NORM);
    step("lu_rt", 0, 6, 9, 0, 1, 9, 1, 0, 0, 0, 0, E_LU);
    step("lu_unused", 0, 9, 2, 0, 1, 9, 1, 0, 0, 0, 0, E_NORM);
    step("lu_mismatch", 0, 4, 5, 1, 1, 6, 1, 0, 0, 0, 0, E_NORM);
    step("lu_r0", 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, E_NORM);
    for (int i = 0; i < 4; i++) step("memw_mask", 0, 3, 0, 1, 0, 3, 1, 1, 1, 1, 1, E_MEMW);
    step("memw_then_lu", 0, 3, 0, 1, 0, 3, 1, 1, 0, 0, 1, E_LU);
    step("post_lu", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM);
    step("mispred", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_MISP);
    step("mispred_ifb", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, E_MISP);
    step("if_busy", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_IFB);
    step("memw_ifb", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_MEMW);
    step("halt_mispred", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, E_MISP);
    step("halt", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_IFB);
    step("drain_busy1", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, E_DRNB);
    step("drain_busy2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_DRNB);
    step("drain3", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, E_DRN);
    step("drain2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_DRN);
    step("drain1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_DRN);
    step("halted0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_HALT);
    step("halted1", 0, 3, 0, 1, 0, 3, 1, 1, 1, 1, 1, E_HALT);
    step("halted2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_HALT);
    step("rst_halted", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_RST);
    step("run_again", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM);
`ifdef PIPELINE_HAZARD_CTRL_PERF_CNT_EN
    step("perf_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST);
    step("perf_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM);
    @(negedge clk);
    chk("cnt_lu_clear", 32'(cnt_load_use), 32'd0);
    chk("cnt_cyc_clear", 32'(cnt_cycles), 32'd0);
    step("perf_mp", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_MISP);
    step("perf_mw", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MEMW);
    for (int i = 0; i < 20; i++) step("perf_lu", 0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, E_LU);
    step("perf_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM);
    @(negedge clk);
    chk("cnt_lu_sat", 32'(cnt_load_use), 32'd15);
    chk("cnt_mispred", 32'(cnt_mispred), 32'd1);
    chk("cnt_mem_wait", 32'(cnt_mem_wait), 32'd1);
    chk("cnt_cycles_sat", 32'(cnt_cycles), 32'd15);
`endif
    @(posedge clk);
    @(posedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
